dm_slot_allocator: RTL

DM_SLOT_ALLOCATOR -- requirements
Module: dm_slot_allocator

---
 rtl/dm_slot_allocator.sv | 95 +++++++++
 1 files changed

// File: rtl/dm_slot_allocator.sv
// Bitmap slot allocator: lowest-free-index allocation with validated frees.
// One response per accepted alloc; illegal frees flag an error next cycle.
module dm_slot_allocator #(
    parameter int                NUM_SLOTS = 16,
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE      = 1,
    parameter int                GRANULE   = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    output logic                         rsp_valid,
    output logic [ADDR_W-1:0]            rsp_addr,
    input  logic                         free_valid,
    input  logic [ADDR_W-1:0]            free_addr,
    output logic                         free_err,
    output logic [$clog2(NUM_SLOTS+1)-1:0] in_use,
    output logic                         full,
    output logic                         empty
);

    localparam int IDXW = $clog2(NUM_SLOTS);
    localparam int IW   = $clog2(NUM_SLOTS + 1);
    localparam int GSH  = $clog2(GRANULE);
    localparam logic [ADDR_W-1:0] GMASK = ADDR_W'(GRANULE - 1);
    localparam logic [ADDR_W-1:0] NSLOT = ADDR_W'(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] bitmap;
    logic [NUM_SLOTS-1:0] set_mask;
    logic [NUM_SLOTS-1:0] clr_mask;
    logic [IW-1:0]        cnt;
    logic [IDXW-1:0]      alloc_idx;
    logic [IDXW-1:0]      free_idx;
    logic [ADDR_W-1:0]    diff;
    logic [ADDR_W-1:0]    slot_off;
    logic                 alloc_go;
    logic                 free_ok;
    logic                 free_go;
    logic                 free_bad;

    assign alloc_ready = ~&bitmap;
    assign alloc_go    = alloc_valid && alloc_ready;

    // Descending scan so the lowest clear index is the last write.
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!bitmap[i]) alloc_idx = IDXW'(i);
        end
    end

    assign diff     = free_addr - BASE;
    assign slot_off = diff >> GSH;
    assign free_idx = slot_off[IDXW-1:0];

    // Range is checked before the bitmap bit is trusted.
    always_comb begin
        free_ok = 1'b0;
        if (free_addr >= BASE && (diff & GMASK) == '0 && slot_off < NSLOT)
            free_ok = bitmap[free_idx];
    end

    assign free_go  = free_valid && free_ok;
    assign free_bad = free_valid && !free_ok;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (alloc_go) set_mask[alloc_idx] = 1'b1;
        if (free_go)  clr_mask[free_idx]  = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bitmap    <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            free_err  <= 1'b0;
        end else begin
            bitmap    <= (bitmap | set_mask) & ~clr_mask;
            cnt       <= cnt + IW'(alloc_go) - IW'(free_go);
            rsp_valid <= alloc_go;
            free_err  <= free_bad;
            if (alloc_go)
                rsp_addr <= BASE + (ADDR_W'(alloc_idx) << GSH);
        end
    end

    assign in_use = cnt;
    assign full   = (cnt == IW'(NUM_SLOTS));
    assign empty  = (cnt == '0);

endmodule
